// File: rtl/pic_8259_pkg.sv
// rtl/pic_8259_pkg.sv - shared states, bit positions and defaults for the 8259A command front end
package pic_8259_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } pic_state_t;

   localparam logic [7:0] IMR_RESET_DEFAULT = 8'hFF;

   // With A0=0, D4 separates ICW1 from OCWs and D3 separates OCW3 from OCW2
   localparam int CMD_ICW1_BIT = 4;
   localparam int CMD_OCW3_BIT = 3;

   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;
   localparam int ICW1_LTIM = 3;

   localparam int ICW4_AEOI = 1;
   localparam int ICW4_SFNM = 4;

   localparam int OCW2_R   = 7;
   localparam int OCW2_SL  = 6;
   localparam int OCW2_EOI = 5;

   localparam int OCW3_ESMM = 6;
   localparam int OCW3_SMM  = 5;
   localparam int OCW3_P    = 2;
   localparam int OCW3_RR   = 1;
   localparam int OCW3_RIS  = 0;

   function automatic pic_state_t next_after_icw2(input logic sngl, input logic ic4);
      if (!sngl)
         return ST_WAIT_ICW3;
      else if (ic4)
         return ST_WAIT_ICW4;
      else
         return ST_READY;
   endfunction

   function automatic pic_state_t next_after_icw3(input logic ic4);
      return ic4 ? ST_WAIT_ICW4 : ST_READY;
   endfunction

endpackage

// File: rtl/pic_bus_strobe_detect.sv
// rtl/pic_bus_strobe_detect.sv - bus input registers and rising-edge write strobe
module pic_bus_strobe_detect
   import pic_8259_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_cs_n,
   input  logic       i_we_n,
   input  logic       i_a0,
   input  logic [7:0] i_data,
   output logic       o_wr_strobe,
   output logic       o_wr_a0,
   output logic [7:0] o_wr_data
);

   logic       r_cs_q;
   logic       r_we_q;
   logic       r_a0_q;
   logic [7:0] r_d_q;
   logic       r_wr_strobe;
   logic       r_wr_a0;
   logic [7:0] r_wr_data;
   logic       w_strobe;

   // Write completes on the low-to-high transition of the strobe while selected
   assign w_strobe = !r_cs_q && !r_we_q && i_we_n;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cs_q      <= 1'b1;
         r_we_q      <= 1'b1;
         r_a0_q      <= 1'b0;
         r_d_q       <= 8'h00;
         r_wr_strobe <= 1'b0;
         r_wr_a0     <= 1'b0;
         r_wr_data   <= 8'h00;
      end else begin
         r_cs_q      <= i_cs_n;
         r_we_q      <= i_we_n;
         r_a0_q      <= i_a0;
         r_d_q       <= i_data;
         r_wr_strobe <= w_strobe;
         // Address/data come from the last sample taken while the strobe was low
         r_wr_a0     <= r_a0_q;
         r_wr_data   <= r_d_q;
      end
   end

   assign o_wr_strobe = r_wr_strobe;
   assign o_wr_a0     = r_wr_a0;
   assign o_wr_data   = r_wr_data;

endmodule

// File: rtl/pic_control_sequencer.sv
// rtl/pic_control_sequencer.sv - ICW/OCW decode, init sequencer and register read mux
module pic_control_sequencer
   import pic_8259_pkg::*;
#(
   parameter logic [7:0] IMR_RESET = IMR_RESET_DEFAULT
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       chip_select,
   input  logic       write_enable,
   input  logic       read_enable,
   input  logic       A0,
   input  logic [7:0] data_bus_in,
   input  logic [7:0] irr_in,
   input  logic [7:0] isr_in,
   output logic [7:0] data_out,
   output logic       data_out_enable,
   output logic       init_done,
   output logic [4:0] vector_base,
   output logic       level_triggered,
   output logic       single_mode,
   output logic [7:0] cascade_config,
   output logic       auto_eoi,
   output logic       special_fully_nested,
   output logic [7:0] imr,
   output logic       eoi_pulse,
   output logic       eoi_specific,
   output logic [2:0] eoi_level,
   output logic       rotate,
   output logic       read_isr_select,
   output logic       special_mask,
   output logic       poll_pulse
);

   logic       w_wr_strobe;
   logic       w_wr_a0;
   logic [7:0] w_wr_data;

   pic_state_t r_state;
   logic       r_ic4;
   logic       r_init_done;
   logic [4:0] r_vector_base;
   logic       r_ltim;
   logic       r_sngl;
   logic [7:0] r_cascade;
   logic       r_aeoi;
   logic       r_sfnm;
   logic [7:0] r_imr;
   logic       r_eoi_pulse;
   logic       r_eoi_specific;
   logic [2:0] r_eoi_level;
   logic       r_rotate;
   logic       r_read_isr;
   logic       r_smm;
   logic       r_poll_pulse;

   pic_bus_strobe_detect u_strobe (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_cs_n      (chip_select),
      .i_we_n      (write_enable),
      .i_a0        (A0),
      .i_data      (data_bus_in),
      .o_wr_strobe (w_wr_strobe),
      .o_wr_a0     (w_wr_a0),
      .o_wr_data   (w_wr_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_ic4          <= 1'b0;
         r_init_done    <= 1'b0;
         r_vector_base  <= 5'h00;
         r_ltim         <= 1'b0;
         r_sngl         <= 1'b0;
         r_cascade      <= 8'h00;
         r_aeoi         <= 1'b0;
         r_sfnm         <= 1'b0;
         r_imr          <= IMR_RESET;
         r_eoi_pulse    <= 1'b0;
         r_eoi_specific <= 1'b0;
         r_eoi_level    <= 3'd0;
         r_rotate       <= 1'b0;
         r_read_isr     <= 1'b0;
         r_smm          <= 1'b0;
         r_poll_pulse   <= 1'b0;
      end else begin
         r_eoi_pulse  <= 1'b0;
         r_poll_pulse <= 1'b0;
         if (w_wr_strobe) begin
            if (!w_wr_a0 && w_wr_data[CMD_ICW1_BIT]) begin
               // ICW1 restarts initialisation from any state
               r_ltim      <= w_wr_data[ICW1_LTIM];
               r_sngl      <= w_wr_data[ICW1_SNGL];
               r_ic4       <= w_wr_data[ICW1_IC4];
               r_imr       <= 8'h00;
               r_init_done <= 1'b0;
               r_smm       <= 1'b0;
               r_read_isr  <= 1'b0;
               r_aeoi      <= 1'b0;
               r_sfnm      <= 1'b0;
               r_cascade   <= 8'h00;
               r_state     <= ST_WAIT_ICW2;
            end else if (w_wr_a0) begin
               case (r_state)
                  ST_WAIT_ICW2: begin
                     r_vector_base <= w_wr_data[7:3];
                     r_state       <= next_after_icw2(r_sngl, r_ic4);
                     if (next_after_icw2(r_sngl, r_ic4) == ST_READY)
                        r_init_done <= 1'b1;
                  end
                  ST_WAIT_ICW3: begin
                     r_cascade <= w_wr_data;
                     r_state   <= next_after_icw3(r_ic4);
                     if (next_after_icw3(r_ic4) == ST_READY)
                        r_init_done <= 1'b1;
                  end
                  ST_WAIT_ICW4: begin
                     r_aeoi      <= w_wr_data[ICW4_AEOI];
                     r_sfnm      <= w_wr_data[ICW4_SFNM];
                     r_state     <= ST_READY;
                     r_init_done <= 1'b1;
                  end
                  ST_READY: r_imr <= w_wr_data;
                  default: ;
               endcase
            end else if (r_state == ST_READY) begin
               if (!w_wr_data[CMD_OCW3_BIT]) begin
                  if (w_wr_data[OCW2_EOI]) begin
                     r_eoi_pulse    <= 1'b1;
                     r_eoi_specific <= w_wr_data[OCW2_SL];
                     r_eoi_level    <= w_wr_data[2:0];
                     r_rotate       <= w_wr_data[OCW2_R];
                  end
               end else begin
                  if (w_wr_data[OCW3_RR])
                     r_read_isr <= w_wr_data[OCW3_RIS];
                  if (w_wr_data[OCW3_ESMM])
                     r_smm <= w_wr_data[OCW3_SMM];
                  if (w_wr_data[OCW3_P])
                     r_poll_pulse <= 1'b1;
               end
            end
         end
      end
   end

   assign data_out_enable = !chip_select && !read_enable;
   assign data_out        = A0 ? r_imr : (r_read_isr ? isr_in : irr_in);

   assign init_done            = r_init_done;
   assign vector_base          = r_vector_base;
   assign level_triggered      = r_ltim;
   assign single_mode          = r_sngl;
   assign cascade_config       = r_cascade;
   assign auto_eoi             = r_aeoi;
   assign special_fully_nested = r_sfnm;
   assign imr                  = r_imr;
   assign eoi_pulse            = r_eoi_pulse;
   assign eoi_specific         = r_eoi_specific;
   assign eoi_level            = r_eoi_level;
   assign rotate               = r_rotate;
   assign read_isr_select      = r_read_isr;
   assign special_mask         = r_smm;
   assign poll_pulse           = r_poll_pulse;

endmodule

// File: tb/tb_pic_control_sequencer.sv
// tb/tb_pic_control_sequencer.sv - directed and randomized checks against a behavioural 8259A command model
module tb_pic_control_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       chip_select = 1'b1;
   logic       write_enable = 1'b1;
   logic       read_enable = 1'b1;
   logic       A0 = 1'b0;
   logic [7:0] data_bus_in = 8'h00;
   logic [7:0] irr_in = 8'h00;
   logic [7:0] isr_in = 8'h00;
   logic [7:0] data_out;
   logic       data_out_enable;
   logic       init_done;
   logic [4:0] vector_base;
   logic       level_triggered;
   logic       single_mode;
   logic [7:0] cascade_config;
   logic       auto_eoi;
   logic       special_fully_nested;
   logic [7:0] imr;
   logic       eoi_pulse;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       rotate;
   logic       read_isr_select;
   logic       special_mask;
   logic       poll_pulse;

   int checks = 0;
   int failures = 0;

   pic_control_sequencer dut (
      .clock(clock), .reset(reset), .chip_select(chip_select), .write_enable(write_enable),
      .read_enable(read_enable), .A0(A0), .data_bus_in(data_bus_in), .irr_in(irr_in),
      .isr_in(isr_in), .data_out(data_out), .data_out_enable(data_out_enable),
      .init_done(init_done), .vector_base(vector_base), .level_triggered(level_triggered),
      .single_mode(single_mode), .cascade_config(cascade_config), .auto_eoi(auto_eoi),
      .special_fully_nested(special_fully_nested), .imr(imr), .eoi_pulse(eoi_pulse),
      .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rotate(rotate),
      .read_isr_select(read_isr_select), .special_mask(special_mask), .poll_pulse(poll_pulse)
   );

   always #5 clock = ~clock;

   // Model: a list of ICWs still owed after ICW1, and the configuration they build
   int         m_pending[$];
   logic       m_ready, m_init, m_ltim, m_sngl, m_aeoi, m_sfnm, m_ris, m_smm;
   logic [4:0] m_vb;
   logic [7:0] m_cas, m_imr;

   task automatic model_reset();
      m_pending.delete();
      m_ready = 0; m_init = 0; m_ltim = 0; m_sngl = 0; m_aeoi = 0; m_sfnm = 0;
      m_ris = 0; m_smm = 0; m_vb = 0; m_cas = 0; m_imr = 8'hFF;
   endtask

   task automatic model_write(input logic a, input logic [7:0] d, output logic eoi,
                              output logic poll, output logic [4:0] eoi_info);
      int k;
      eoi = 0; poll = 0; eoi_info = 0;
      if (!a && d[4]) begin
         m_pending.delete();
         m_pending.push_back(2);
         if (!d[1]) m_pending.push_back(3);
         if (d[0]) m_pending.push_back(4);
         m_ready = 0; m_init = 0; m_ltim = d[3]; m_sngl = d[1];
         m_imr = 0; m_smm = 0; m_ris = 0; m_aeoi = 0; m_sfnm = 0; m_cas = 0;
      end else if (a) begin
         if (m_ready) m_imr = d;
         else if (m_pending.size() > 0) begin
            k = m_pending.pop_front();
            if (k == 2) m_vb = d[7:3];
            else if (k == 3) m_cas = d;
            else begin m_aeoi = d[1]; m_sfnm = d[4]; end
            if (m_pending.size() == 0) begin m_ready = 1; m_init = 1; end
         end
      end else if (m_ready) begin
         if (!d[3]) begin
            if (d[5]) begin eoi = 1; eoi_info = {d[7], d[6], d[2:0]}; end
         end else begin
            if (d[1]) m_ris = d[0];
            if (d[6]) m_smm = d[5];
            if (d[2]) poll = 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, ".init_done"}, 16'(init_done), 16'(m_init));
      check({ctx, ".vector_base"}, 16'(vector_base), 16'(m_vb));
      check({ctx, ".ltim"}, 16'(level_triggered), 16'(m_ltim));
      check({ctx, ".single"}, 16'(single_mode), 16'(m_sngl));
      check({ctx, ".cascade"}, 16'(cascade_config), 16'(m_cas));
      check({ctx, ".aeoi"}, 16'(auto_eoi), 16'(m_aeoi));
      check({ctx, ".sfnm"}, 16'(special_fully_nested), 16'(m_sfnm));
      check({ctx, ".imr"}, 16'(imr), 16'(m_imr));
      check({ctx, ".ris"}, 16'(read_isr_select), 16'(m_ris));
      check({ctx, ".smm"}, 16'(special_mask), 16'(m_smm));
      check({ctx, ".doe_idle"}, 16'(data_out_enable), 16'(0));
   endtask

   task automatic do_write(input logic a, input logic [7:0] d, input int hold);
      logic       e_eoi, e_poll;
      logic [4:0] e_info, got_info;
      logic [3:0] eh, ph;
      @(negedge clock);
      chip_select = 0; A0 = a; data_bus_in = d; write_enable = 0;
      repeat (hold) @(negedge clock);
      // Release select with the strobe and scramble the bus: capture must use the low samples
      write_enable = 1; chip_select = 1; A0 = 1'($urandom); data_bus_in = 8'($urandom);
      model_write(a, d, e_eoi, e_poll, e_info);
      got_info = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         eh[i] = eoi_pulse; ph[i] = poll_pulse;
         if (i == 1) got_info = {rotate, eoi_specific, eoi_level};
      end
      check("eoi_pulse_shape", 16'(eh), e_eoi ? 16'h2 : 16'h0);
      check("poll_pulse_shape", 16'(ph), e_poll ? 16'h2 : 16'h0);
      if (e_eoi) check("eoi_r_sl_level", 16'(got_info), 16'(e_info));
   endtask

   task automatic do_read(input logic a);
      logic [7:0] e;
      @(negedge clock);
      chip_select = 0; read_enable = 0; A0 = a;
      #1;
      e = a ? m_imr : (m_ris ? isr_in : irr_in);
      check("read_enable_out", 16'(data_out_enable), 16'(1));
      check("read_data", 16'(data_out), 16'(e));
      @(negedge clock);
      chip_select = 1; read_enable = 1;
   endtask

   initial begin
      logic       ra;
      logic [7:0] rd;
      model_reset();
      #2 reset = 1;
      #1 check_all("reset");
      repeat (2) @(negedge clock);
      reset = 0;

      do_write(0, 8'h13, 1); check_all("single_icw1");
      do_write(1, 8'h20, 1); check_all("single_icw2");
      do_write(1, 8'h03, 2); check_all("single_icw4");
      check("single_vb", 16'(vector_base), 16'h04);
      check("single_done", 16'(init_done), 16'h1);

      do_write(0, 8'h11, 1); check_all("casc_icw1");
      do_write(1, 8'h40, 1); check_all("casc_icw2");
      do_write(1, 8'h04, 1); check_all("casc_icw3");
      check("casc_not_ready", 16'(init_done), 16'h0);
      do_write(1, 8'h01, 1); check_all("casc_icw4");
      check("casc_cfg", 16'(cascade_config), 16'h04);

      do_write(1, 8'hA5, 1); check_all("ocw1");
      do_read(1);
      do_write(0, 8'h63, 1); check_all("ocw2_specific");
      do_write(0, 8'h20, 1); check_all("ocw2_nonspecific");
      do_write(0, 8'h20, 5); check_all("ocw2_held");
      do_write(0, 8'h0B, 1); check_all("ocw3_ris");
      isr_in = 8'h10; irr_in = 8'h42;
      do_read(0);
      do_write(0, 8'h0C, 1); check_all("ocw3_poll");
      do_write(0, 8'h68, 1); check_all("ocw3_smm");

      do_write(0, 8'h11, 1);
      do_write(1, 8'h40, 1);
      @(negedge clock);
      #2 reset = 1;
      model_reset();
      #1 check_all("mid_reset");
      @(negedge clock);
      reset = 0;
      do_write(1, 8'h55, 1); check_all("idle_a0_ignored");
      do_write(0, 8'h20, 1); check_all("idle_ocw_ignored");

      for (int n = 0; n < 80; n++) begin
         ra = 1'($urandom);
         rd = 8'($urandom);
         if ($urandom_range(0, 5) == 0) begin ra = 0; rd[4] = 1; end
         else if (!ra) rd[4] = 0;
         do_write(ra, rd, int'($urandom_range(1, 3)));
         check_all("rand");
         irr_in = 8'($urandom); isr_in = 8'($urandom);
         do_read(1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
